// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM as two timed half-accesses.
// Define SRAM_CTRL_POSTED_WRITE_EN to release the pipeline as soon as a write is accepted.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_wr;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [16:0] word;
    logic        last;
    logic        dq_drive;
    logic [15:0] dq_out;

    assign word = 17'((addr_q - BASE_ADDR) >> 2);
    assign last = (cnt == LAST_CNT);

    assign sram_dq   = dq_drive ? dq_out : 16'bz;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            read_data <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Request is captured once; later input changes are ignored until IDLE.
            if (state == IDLE && (wr_en || rd_en)) begin
                op_wr  <= wr_en;
                addr_q <= address;
                data_q <= write_data;
            end
            if (state == LOW && last && !op_wr) begin
                read_data[15:0] <= sram_dq;
            end
            if (state == HIGH && last && !op_wr) begin
                read_data[31:16] <= sram_dq;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        sram_addr = 18'd0;
        sram_we_n = 1'b1;
        dq_drive  = 1'b0;
        dq_out    = data_q[15:0];
        case (state)
            IDLE: begin
                ready = !(wr_en || rd_en);
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                if (wr_en) begin
                    ready = 1'b1;
                end
`endif
                if (wr_en || rd_en) begin
                    state_nxt = LOW;
                    cnt_nxt   = 4'd0;
                end
            end
            LOW: begin
                sram_addr = {word, 1'b0};
                sram_we_n = !op_wr;
                dq_drive  = op_wr;
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HIGH: begin
                sram_addr = {word, 1'b1};
                sram_we_n = !op_wr;
                dq_drive  = op_wr;
                dq_out    = data_q[31:16];
                if (last) begin
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                    state_nxt = op_wr ? IDLE : DONE;
`else
                    state_nxt = DONE;
`endif
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // The pipeline must never stall while the controller is held in reset.
        if (rst) begin
            ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized and directed bench for sram_controller against a word-level memory reference.
// Honours SRAM_CTRL_POSTED_WRITE_EN when the design is built with it.
module tb_sram_controller;

    localparam int          W    = 3;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = 0;

    logic [15:0] mem [0:255];
    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rd;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Half-word SRAM: drives the bus whenever not being written.
    assign sram_dq = sram_we_n ? mem[sram_addr[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
    end

    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] data, input bit scramble);
        logic [16:0] word;
        logic [31:0] exp;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        bit          posted;
        bit          exp_ready;
        bit          exp_we_n;
        word   = 17'((addr - BASE) >> 2);
        posted = 1'b0;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
        posted = wr;
`endif
        exp = ref_mem[word[5:0]];
        if (wr) ref_mem[word[5:0]] = data;
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        for (int k = 0; k <= 2*W+1; k++) begin
            @(negedge clk);
            exp_ready = (k == 0) ? posted : (k == 2*W+1);
            exp_addr  = (k >= 1 && k <= W) ? {word, 1'b0} :
                        (k > W && k <= 2*W) ? {word, 1'b1} : 18'd0;
            exp_we_n  = !(wr && k >= 1 && k <= 2*W);
            tests++;
            if (ready !== exp_ready) begin
                fails++; $display("FAIL ready k=%0d addr=%h got %b want %b", k, addr, ready, exp_ready);
            end
            tests++;
            if (sram_addr !== exp_addr) begin
                fails++; $display("FAIL sram_addr k=%0d got %h want %h", k, sram_addr, exp_addr);
            end
            tests++;
            if (sram_we_n !== exp_we_n) begin
                fails++; $display("FAIL we_n k=%0d got %b want %b", k, sram_we_n, exp_we_n);
            end
            if (!exp_we_n) begin
                exp_dq = (k <= W) ? data[15:0] : data[31:16];
                tests++;
                if (sram_dq !== exp_dq) begin
                    fails++; $display("FAIL dq k=%0d got %h want %h", k, sram_dq, exp_dq);
                end
            end
            if (!wr && k == W+1) begin
                tests++;
                if (read_data[15:0] !== exp[15:0]) begin
                    fails++; $display("FAIL rd_low got %h want %h", read_data[15:0], exp[15:0]);
                end
            end
            if (k == 2*W+1) begin
                done_cyc = cyc;
                if (!wr) last_rd = exp;
                tests++;
                if (read_data !== last_rd) begin
                    fails++; $display("FAIL read_data addr=%h got %h want %h", addr, read_data, last_rd);
                end
            end
            if (k < 2*W+1) begin
                @(posedge clk); #1;
                if (posted) begin wr_en = 1'b0; rd_en = 1'b0; end
                if (scramble) begin address = $urandom; write_data = $urandom; end
            end
        end
    endtask

    task automatic idle_req();
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = BASE; write_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", ready); end
        tests++;
        if (sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
            fails++; $display("FAIL rst_bus got we_n=%b addr=%h want 1/0", sram_we_n, sram_addr);
        end
        tests++;
        if (read_data !== 32'd0) begin fails++; $display("FAIL rst_rd got %h want 0", read_data); end
        tests++;
        if ({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n} !== 4'b0000) begin
            fails++; $display("FAIL ties got %b want 0000", {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n});
        end
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", ready); end
        last_rd = 32'd0;
    endtask

    task automatic test_directed();
        run_txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
        idle_req();
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        tests++;
        if (read_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL directed_rd got %h want deadbeef", read_data);
        end
        idle_req();
    endtask

    task automatic test_priority();
        run_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        idle_req();
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        idle_req();
    endtask

    task automatic test_back_to_back();
        int t1;
        run_txn(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        t1 = done_cyc;
        run_txn(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0);
        tests++;
        if (done_cyc - t1 != 2*W+2) begin
            fails++; $display("FAIL b2b_gap got %0d want %0d", done_cyc - t1, 2*W+2);
        end
        idle_req();
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        wr_en = 1'b1; rd_en = 1'b0; address = BASE + 32'd160; write_data = $urandom;
        repeat (W+2) @(posedge clk);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        tests++;
        if (ready !== 1'b1) begin fails++; $display("FAIL abort_rst_ready got %b want 1", ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
            fails++; $display("FAIL abort_state got ready=%b we_n=%b addr=%h want 1/1/0",
                              ready, sram_we_n, sram_addr);
        end
        tests++;
        if (sram_dq !== mem[0]) begin fails++; $display("FAIL abort_dq got %h want %h", sram_dq, mem[0]); end
        tests++;
        if (read_data !== 32'd0) begin fails++; $display("FAIL abort_rd got %h want 0", read_data); end
        last_rd = 32'd0;
    endtask

    task automatic test_random();
        bit          wr;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            a  = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            run_txn(wr, !wr || ($urandom_range(0, 3) == 0), a, $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) idle_req();
        end
        idle_req();
    endtask

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    task automatic test_posted();
        bit exp_ready;
        ref_mem[0] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024; write_data = 32'hCAFE_F00D;
        for (int k = 0; k <= 4*W+2; k++) begin
            @(negedge clk);
            exp_ready = (k == 0) || (k == 4*W+2);
            tests++;
            if (ready !== exp_ready) begin
                fails++; $display("FAIL posted_ready k=%0d got %b want %b", k, ready, exp_ready);
            end
            if (k == 0) begin
                @(posedge clk); #1;
                wr_en = 1'b0; rd_en = 1'b1; address = 32'd1028;
            end else if (k < 4*W+2) begin
                @(posedge clk); #1;
            end
        end
        last_rd = ref_mem[1];
        tests++;
        if (read_data !== last_rd) begin
            fails++; $display("FAIL posted_rd got %h want %h", read_data, last_rd);
        end
        idle_req();
        run_txn(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        idle_req();
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        last_rd = 32'h0;
        test_reset();
        test_directed();
        test_priority();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef SRAM_CTRL_POSTED_WRITE_EN
        test_posted();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
